instruction_rom: RTL and testbench



---
 rtl/instruction_rom_if.sv | 19 +
 rtl/instruction_rom.sv | 48 ++++
 tb/tb_instruction_rom.sv | 128 ++++++++++++
 3 files changed

// File: rtl/instruction_rom_if.sv
// Fetch-side bus between the PC/fetch stage and the program ROM.
// The master drives the word address, and the slave returns the registered instruction.
interface instruction_rom_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] Address_Instruction_Bus;
    logic [DATA_WIDTH-1:0] Instruction;

    modport master (
        output Address_Instruction_Bus,
        input  Instruction
    );

    modport slave (
        input  Address_Instruction_Bus,
        output Instruction
    );
endinterface

// File: rtl/instruction_rom.sv
// Read-only program memory with a fixed lookup table and a single registered read port.
// The output is cleared to NOP_WORD asynchronously while rst is high.
module instruction_rom #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic               clk,
    input  logic               rst,
    instruction_rom_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] rom_t [DEPTH];

    function automatic rom_t build_rom();
        rom_t rom;
        for (int i = 0; i < DEPTH; i++) begin
            rom[i] = NOP_WORD;
        end
        rom[0] = DATA_WIDTH'(16'h0000);
        rom[1] = DATA_WIDTH'(16'h1105);
        rom[2] = DATA_WIDTH'(16'h120A);
        rom[3] = DATA_WIDTH'(16'h2312);
        rom[4] = DATA_WIDTH'(16'h3400);
        rom[5] = DATA_WIDTH'(16'h4501);
        rom[6] = DATA_WIDTH'(16'h5600);
        rom[7] = DATA_WIDTH'(16'hF000);
        return rom;
    endfunction

    localparam rom_t ROM = build_rom();

    logic [DATA_WIDTH-1:0] rom_word;

    // An array index is used instead of a case so that an unknown address reads back as X.
    always_comb begin
        rom_word = ROM[bus.Address_Instruction_Bus];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.Instruction <= NOP_WORD;
        end else begin
            bus.Instruction <= rom_word;
        end
    end
endmodule

// File: tb/tb_instruction_rom.sv
// Scoreboard bench for instruction_rom.
// The stimulus side queues the expected word for each fetch, and a negedge monitor compares it against the DUT output.
module tb_instruction_rom;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic [15:0] ref_rom [256];
    logic [15:0] exp_q [$];

    instruction_rom_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

    instruction_rom #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(16),
        .NOP_WORD  (16'h0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_rom[i] = 16'h0000;
        ref_rom[1] = 16'h1105;
        ref_rom[2] = 16'h120A;
        ref_rom[3] = 16'h2312;
        ref_rom[4] = 16'h3400;
        ref_rom[5] = 16'h4501;
        ref_rom[6] = 16'h5600;
        ref_rom[7] = 16'hF000;
    end

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, required, $time);
        end
    endtask

    // The monitor takes one queued expectation on every falling edge after a read.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                check("fetch", bus.Instruction, exp_q.pop_front());
            end
        end
    end

    task automatic fetch(input logic [7:0] a);
        @(negedge clk);
        bus.Address_Instruction_Bus = a;
        @(posedge clk);
        exp_q.push_back(ref_rom[a]);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] unprog [3];
        int budget;

        rst = 1'b1;
        bus.Address_Instruction_Bus = 8'h03;
        #1;
        check("reset_immediate", bus.Instruction, 16'h0000);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold", bus.Instruction, 16'h0000);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int a = 0; a < 8; a++) fetch(8'(a));

        fetch(8'h02);
        #2;
        bus.Address_Instruction_Bus = 8'h05;
        @(negedge clk);
        #1;
        check("hold_mid_cycle", bus.Instruction, 16'h120A);
        @(posedge clk);
        exp_q.push_back(ref_rom[5]);

        unprog[0] = 8'h08;
        unprog[1] = 8'h80;
        unprog[2] = 8'hFF;
        for (int i = 0; i < 3; i++) fetch(unprog[i]);

        fetch(8'h07);
        @(negedge clk);
        #1;
        check("pre_reset_word", bus.Instruction, 16'hF000);
        rst = 1'b1;
        #1;
        check("reset_mid_run", bus.Instruction, 16'h0000);
        rst = 1'b0;
        fetch(8'h01);

        for (int i = 0; i < 4; i++) fetch(8'h06);

        for (int i = 0; i < 150; i++) begin
            ra = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            fetch(ra);
        end

        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left after budget, expected 0", exp_q.size());
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
